// File: rtl/agc_io_channel_file.sv
// rtl/agc_io_channel_file.sv - latched input channels, handshaked output holding registers and status word for the AGC core
module agc_io_channel_file #(
  parameter int WIDTH = 15,
  parameter int N_IN  = 5,
  parameter int N_OUT = 4,
  parameter int SEL_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_IN*WIDTH-1:0]  in_data,
  input  logic [N_IN-1:0]        in_valid,
  input  logic [SEL_W-1:0]       sel_read,
  input  logic                   en_read,
  input  logic                   stall,
  output logic [WIDTH-1:0]       data_read,
  input  logic [SEL_W-1:0]       sel_write,
  input  logic [WIDTH-1:0]       data_write,
  input  logic                   en_write,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic                   irq
);

  localparam logic [SEL_W-1:0] STATUS_SEL = '1;
  localparam int STAT_USED = N_IN + 2 * N_OUT;

  // The select space must hold every channel plus the status word, and the status fields must fit a word.
  if (N_IN + N_OUT >= 2 ** SEL_W || STAT_USED > WIDTH) begin : g_param_check
    $error("agc_io_channel_file: select map or status word does not fit the chosen parameters");
  end

  logic [N_IN-1:0][WIDTH-1:0]  in_reg_q, in_reg_d;
  logic [N_IN-1:0]             fresh_q, fresh_d;
  logic [N_OUT-1:0][WIDTH-1:0] out_reg_q, out_reg_d;
  logic [N_OUT-1:0]            out_valid_q, out_valid_d;
  logic [N_OUT-1:0]            overflow_q, overflow_d;
  logic [WIDTH-1:0]            data_read_q, data_read_d;

  logic [WIDTH-1:0]            status_word;
  logic [WIDTH-1:0]            rd_word;
  logic                        rd_fire;

  // Status word assembled from the live flag registers; unused upper bits read 0.
  always_comb begin
    status_word = '0;
    status_word[STAT_USED-1:0] = {overflow_q, out_valid_q, fresh_q};
  end

  // Read mux over the select map; unmapped selects fall through to 0.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel_read == SEL_W'(k)) rd_word = in_reg_q[k];
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (sel_read == SEL_W'(N_IN + k)) rd_word = out_reg_q[k];
    end
    if (sel_read == STATUS_SEL) rd_word = status_word;
  end

  // Input side: serial loads set fresh, a consuming core read clears it, and a load in the same cycle wins.
  always_comb begin
    rd_fire     = en_read & ~stall;
    data_read_d = rd_fire ? rd_word : data_read_q;
    for (int k = 0; k < N_IN; k++) begin
      in_reg_d[k] = in_valid[k] ? in_data[k*WIDTH +: WIDTH] : in_reg_q[k];
      fresh_d[k]  = in_valid[k] | (fresh_q[k] & ~(rd_fire && sel_read == SEL_W'(k)));
    end
  end

  // Output side: core writes fill the holding register, a completed handshake empties it,
  // and overwriting a still-pending word that is not leaving this cycle records an overflow.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      logic wr_k;
      logic xfer_k;
      logic clr_k;
      wr_k   = en_write && sel_write == SEL_W'(N_IN + k);
      xfer_k = out_valid_q[k] & out_ready[k];
      clr_k  = en_write && sel_write == STATUS_SEL && data_write[N_IN + N_OUT + k];
      out_reg_d[k]   = wr_k ? data_write : out_reg_q[k];
      out_valid_d[k] = wr_k | (out_valid_q[k] & ~xfer_k);
      overflow_d[k]  = (overflow_q[k] & ~clr_k) | (wr_k & out_valid_q[k] & ~xfer_k);
    end
  end

  // State registers; reset clears everything immediately, including pending output handshakes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_reg_q    <= '0;
      fresh_q     <= '0;
      out_reg_q   <= '0;
      out_valid_q <= '0;
      overflow_q  <= '0;
      data_read_q <= '0;
    end else begin
      in_reg_q    <= in_reg_d;
      fresh_q     <= fresh_d;
      out_reg_q   <= out_reg_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      data_read_q <= data_read_d;
    end
  end

  assign data_read = data_read_q;
  assign out_data  = out_reg_q;
  assign out_valid = out_valid_q;
  assign irq       = |fresh_q;

endmodule

// File: tb/tb_agc_io_channel_file.sv
// tb/tb_agc_io_channel_file.sv - table-driven and scoreboard bench for agc_io_channel_file
module tb_agc_io_channel_file;
  localparam int WIDTH = 15;
  localparam int N_IN  = 5;
  localparam int N_OUT = 4;
  localparam int SEL_W = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N_IN*WIDTH-1:0]  in_data;
  logic [N_IN-1:0]        in_valid;
  logic [SEL_W-1:0]       sel_read;
  logic                   en_read;
  logic                   stall;
  logic [WIDTH-1:0]       data_read;
  logic [SEL_W-1:0]       sel_write;
  logic [WIDTH-1:0]       data_write;
  logic                   en_write;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic                   irq;

  agc_io_channel_file #(.WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .sel_read(sel_read), .en_read(en_read), .stall(stall), .data_read(data_read),
    .sel_write(sel_write), .data_write(data_write), .en_write(en_write),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [2:0]  ich;
    logic [14:0] iword;
    logic        rd;
    logic [3:0]  rsel;
    logic        stl;
    logic        wr;
    logic [3:0]  wsel;
    logic [14:0] wdata;
    logic [3:0]  rdy;
    logic [14:0] exp_dr;
    logic        exp_irq;
    logic [3:0]  exp_ov;
  } vec_t;

  vec_t        vecs[26];
  logic [14:0] sb[$];
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    in_valid = '0; in_data = '0; en_read = 1'b0; sel_read = '0; stall = 1'b0;
    en_write = 1'b0; sel_write = '0; data_write = '0; out_ready = '0;
  endtask

  task automatic drive(input vec_t v);
    idle();
    if (v.iv) begin
      in_valid = 5'(1) << v.ich;
      in_data[int'(v.ich)*WIDTH +: WIDTH] = v.iword;
    end
    en_read = v.rd; sel_read = v.rsel; stall = v.stl;
    en_write = v.wr; sel_write = v.wsel; data_write = v.wdata;
    out_ready = v.rdy;
  endtask

  task automatic pop_chk(input string name);
    if (sb.size() == 0) chk({name, " scoreboard empty"}, 64'd1, 64'd0);
    else chk(name, 64'(data_read), 64'(sb.pop_front()));
  endtask

  initial begin
    //           iv  ich   iword     rd  rsel  stl wr  wsel  wdata     rdy      exp_dr    irq  exp_ov
    vecs[0]  = '{1'b1,3'd2,15'h1234,1'b0,4'd0, 1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0000,1'b1,4'b0000};
    vecs[1]  = '{1'b0,3'd0,15'h0000,1'b1,4'd2, 1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h1234,1'b0,4'b0000};
    vecs[2]  = '{1'b0,3'd0,15'h0000,1'b1,4'd15,1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0000,1'b0,4'b0000};
    vecs[3]  = '{1'b1,3'd0,15'h0555,1'b0,4'd0, 1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0000,1'b1,4'b0000};
    vecs[4]  = '{1'b0,3'd0,15'h0000,1'b1,4'd0, 1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0555,1'b0,4'b0000};
    vecs[5]  = '{1'b1,3'd0,15'h0AAA,1'b1,4'd0, 1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0555,1'b1,4'b0000};
    vecs[6]  = '{1'b0,3'd0,15'h0000,1'b1,4'd0, 1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0AAA,1'b0,4'b0000};
    vecs[7]  = '{1'b0,3'd0,15'h0000,1'b0,4'd0, 1'b0,1'b1,4'd5, 15'h7FFF,4'b0000,15'h0AAA,1'b0,4'b0001};
    vecs[8]  = '{1'b0,3'd0,15'h0000,1'b1,4'd5, 1'b0,1'b1,4'd5, 15'h0001,4'b0000,15'h7FFF,1'b0,4'b0001};
    vecs[9]  = '{1'b0,3'd0,15'h0000,1'b1,4'd15,1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0220,1'b0,4'b0001};
    vecs[10] = '{1'b0,3'd0,15'h0000,1'b0,4'd0, 1'b0,1'b0,4'd0, 15'h0000,4'b0001,15'h0220,1'b0,4'b0000};
    vecs[11] = '{1'b0,3'd0,15'h0000,1'b1,4'd15,1'b0,1'b1,4'd15,15'h0200,4'b0000,15'h0200,1'b0,4'b0000};
    vecs[12] = '{1'b0,3'd0,15'h0000,1'b1,4'd15,1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0000,1'b0,4'b0000};
    vecs[13] = '{1'b0,3'd0,15'h0000,1'b0,4'd0, 1'b0,1'b1,4'd6, 15'h0011,4'b0000,15'h0000,1'b0,4'b0010};
    vecs[14] = '{1'b0,3'd0,15'h0000,1'b0,4'd0, 1'b0,1'b1,4'd6, 15'h0022,4'b0010,15'h0000,1'b0,4'b0010};
    vecs[15] = '{1'b0,3'd0,15'h0000,1'b1,4'd15,1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0040,1'b0,4'b0010};
    vecs[16] = '{1'b0,3'd0,15'h0000,1'b1,4'd6, 1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0022,1'b0,4'b0010};
    vecs[17] = '{1'b1,3'd3,15'h0333,1'b0,4'd0, 1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0022,1'b1,4'b0010};
    vecs[18] = '{1'b0,3'd0,15'h0000,1'b1,4'd2, 1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h1234,1'b1,4'b0010};
    vecs[19] = '{1'b0,3'd0,15'h0000,1'b1,4'd3, 1'b1,1'b0,4'd0, 15'h0000,4'b0000,15'h1234,1'b1,4'b0010};
    vecs[20] = '{1'b0,3'd0,15'h0000,1'b1,4'd3, 1'b1,1'b0,4'd0, 15'h0000,4'b0000,15'h1234,1'b1,4'b0010};
    vecs[21] = '{1'b0,3'd0,15'h0000,1'b1,4'd3, 1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0333,1'b0,4'b0010};
    vecs[22] = '{1'b0,3'd0,15'h0000,1'b1,4'd12,1'b0,1'b0,4'd0, 15'h0000,4'b0000,15'h0000,1'b0,4'b0010};
    vecs[23] = '{1'b0,3'd0,15'h0000,1'b0,4'd0, 1'b0,1'b1,4'd1, 15'h7777,4'b0000,15'h0000,1'b0,4'b0010};
    vecs[24] = '{1'b0,3'd0,15'h0000,1'b1,4'd1, 1'b0,1'b1,4'd12,15'h7777,4'b0000,15'h0000,1'b0,4'b0010};
    vecs[25] = '{1'b0,3'd0,15'h0000,1'b0,4'd0, 1'b0,1'b0,4'd0, 15'h0000,4'b1111,15'h0000,1'b0,4'b0000};

    idle();
    reset = 1'b1;
    #2;
    chk("reset data_read", 64'(data_read), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset irq", 64'(irq), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      @(negedge clock);
      drive(vecs[i]);
      sb.push_back(vecs[i].exp_dr);
      @(posedge clock);
      #1;
      pop_chk($sformatf("vec%0d data_read", i));
      chk($sformatf("vec%0d irq", i), 64'(irq), 64'(vecs[i].exp_irq));
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
    end

    // Core write lands on the same cycle as a handshake: transmitter sees the old word.
    @(negedge clock);
    idle(); en_write = 1'b1; sel_write = 4'd6; data_write = 15'h0055;
    @(posedge clock); #1;
    chk("wdt first out_valid", 64'(out_valid), 64'b0010);
    chk("wdt first out_data1", 64'(out_data[WIDTH +: WIDTH]), 64'h0055);
    @(negedge clock);
    idle(); en_write = 1'b1; sel_write = 4'd6; data_write = 15'h0066; out_ready = 4'b0010;
    #1;
    chk("wdt xfer data", 64'(out_data[WIDTH +: WIDTH]), 64'h0055);
    chk("wdt xfer valid", 64'(out_valid[1]), 64'd1);
    @(posedge clock); #1;
    chk("wdt after out_valid", 64'(out_valid), 64'b0010);
    chk("wdt after out_data1", 64'(out_data[WIDTH +: WIDTH]), 64'h0066);
    @(negedge clock);
    idle(); en_read = 1'b1; sel_read = 4'd15;
    sb.push_back(15'h0040);
    @(posedge clock); #1;
    pop_chk("wdt status no overflow");

    // Back-to-back transfers on output 2 with a write every cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      idle(); en_write = 1'b1; sel_write = 4'd7; data_write = 15'(i + 1); out_ready = 4'b1111;
      @(posedge clock); #1;
      chk($sformatf("b2b%0d out_valid", i), 64'(out_valid), 64'b0100);
    end
    @(negedge clock);
    idle(); en_read = 1'b1; sel_read = 4'd15;
    sb.push_back(15'h0080);
    @(posedge clock); #1;
    pop_chk("b2b status");

    // Mid-run asynchronous reset with out_valid = 0101 and a pending fresh flag.
    @(negedge clock);
    idle(); en_write = 1'b1; sel_write = 4'd5; data_write = 15'h0123;
    in_valid = 5'b10000; in_data[4*WIDTH +: WIDTH] = 15'h0444;
    @(posedge clock); #1;
    chk("pre-reset irq", 64'(irq), 64'd1);
    @(negedge clock);
    idle(); en_read = 1'b1; sel_read = 4'd15;
    sb.push_back(15'h00B0);
    @(posedge clock); #1;
    pop_chk("pre-reset status");
    chk("pre-reset out_valid", 64'(out_valid), 64'b0101);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset irq", 64'(irq), 64'd0);
    chk("async reset data_read", 64'(data_read), 64'd0);
    chk("async reset out_data", 64'(out_data), 64'd0);
    @(negedge clock);
    idle();
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post-reset out_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/agc_io_channel_file.md
# agc_io_channel_file

Parametrised successor to the fixed five-input IO register file between the AGC `Core` and the serial interface modules. It has N_IN latched input channels, fed by serial receivers with valid strobes and per-channel fresh flags. It has N_OUT output channels, each with a single-entry holding register and a valid/ready handshake toward a serial transmitter. A status word exposes fresh, pending and overflow state, and is readable by the core on the same select bus.

## Interface
- WIDTH, 15: data word width (AGC word).
- N_IN, 5: input channel count (DSKY verb/noun, mission time, apogee, perigee).
- N_OUT, 4: output channel count.
- SEL_W, 4: select width. Requires N_IN+N_OUT < 2**SEL_W and N_IN+2*N_OUT <= WIDTH; elaboration error otherwise.
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N_IN*WIDTH  packed input words; channel k at [k*WIDTH +: WIDTH].
- in_valid  input  N_IN  per-channel one-cycle load strobe.
- sel_read  input  SEL_W  core read select.
- en_read  input  1  core read enable; a read only has side effects when this is high.
- stall  input  1  core pipeline stall; freezes data_read.
- data_read  output  WIDTH  registered read data.
- sel_write  input  SEL_W  core write select.
- data_write  input  WIDTH  core write data.
- en_write  input  1  core write enable.
- out_data  output  N_OUT*WIDTH  packed output holding registers.
- out_valid  output  N_OUT  holding register k pending.
- out_ready  input  N_OUT  transmitter k accepts.
- irq  output  1  OR of all fresh flags.

## Operation
- Select map: 0..N_IN-1 are input channels; N_IN..N_IN+N_OUT-1 are output readback; STATUS_SEL = 2**SEL_W-1 is the status word; all other selects read 0.
- Status word:
  - [N_IN-1:0] is fresh.
  - [N_IN+N_OUT-1:N_IN] is out_valid.
  - [N_IN+2*N_OUT-1:N_IN+N_OUT] is overflow.
  - Upper bits are 0.
- Input k on in_valid[k]: in_reg[k] <= in_data word k, fresh[k] <= 1.
- Read with en_read=1 and stall=0:
  - data_read <= the selected word.
  - If the select is input k, fresh[k] <= 0.
  - If in_valid[k] arrives in the same cycle, data_read returns the old in_reg[k], in_reg[k] takes the new word, and fresh[k] stays 1 (set wins).
- With en_read=0 or stall=1, data_read holds and no flag changes.
- Write with en_write=1 to output k:
  - out_reg[k] <= data_write, out_valid[k] <= 1.
  - If out_valid[k] was already 1 and no handshake completes that cycle, overflow[k] <= 1. The new data overwrites the old.
- Write to STATUS_SEL: write-1-to-clear on the overflow field (bit N_IN+N_OUT+k clears overflow[k]). Other status bits are ignored.
- Writes to input, unmapped or readback selects have no effect.
- Handshake k: a transfer occurs when out_valid[k] & out_ready[k]; out_valid[k] <= 0 next cycle. If a core write to k lands in the same cycle, the transfer takes the old data, out_valid stays 1 with the new data, and overflow is not set.
- out_data is always the holding register and is stable while out_valid is 1 until transfer or overwrite.
- irq = |fresh, driven from registers with no combinational path from inputs.

## Timing
- Reset (asynchronous assert, synchronous-style release):
  - All of in_reg, out_reg, fresh, out_valid, overflow and data_read are 0, so irq is 0.
  - Asserting reset mid-handshake drops out_valid immediately.
- Read latency is 1 cycle: select at edge n produces data_read after edge n, matching the ROM/RAM registered-read timing of `Core`.
- in_valid to fresh/irq visible: 1 cycle. in_valid to status-word read showing fresh: 2 cycles.
- Core write to out_valid high: 1 cycle. Back-to-back transfers on one channel are possible every cycle if the core writes every cycle.
- Read and write to the same output select in one cycle: the read returns the pre-write value.
- Status read in the same cycle as a W1C write returns the pre-clear overflow.

## Test plan
- Reset: assert reset mid-run with out_valid=4'b0101 -> all outputs are 0 asynchronously, including irq=0 and data_read=0.
- Input latch/clear:
  - in_valid[2] with word 15'h1234 -> irq=1 next cycle.
  - Read sel 2 with en_read -> data_read=15'h1234, irq=0.
  - Read of STATUS_SEL then -> bit2=0.
- Collision: in_valid[0] with 15'h0AAA on the same cycle as a read of sel 0 (old value 15'h0555) -> data_read=15'h0555, fresh[0]=1, in_reg[0]=15'h0AAA.
- Output handshake:
  - Write sel 5 (output 0) with 15'h7FFF while out_ready=0 -> out_valid[0]=1.
  - Second write 15'h0001 -> overflow[0]=1 (status bit 9), out_data word0=15'h0001.
  - Raise out_ready -> out_valid[0]=0 next cycle.
  - W1C write of 15'h0200 to sel 15 -> overflow[0]=0.
- Write during transfer: out_valid[1]=1 with 15'h0011, out_ready[1]=1, and a core write of 15'h0022 in the same cycle -> the transmitter takes 15'h0011, out_valid[1] stays 1 with 15'h0022, overflow[1]=0.
- Stall: stall=1 while sel_read changes from 2 to 3 with fresh[3]=1 -> data_read holds and fresh[3] stays 1 until stall drops.
